// File: rtl/dmem_arbiter.sv
// Purpose: two-port (core / DMA) arbiter and sequencer for the single-ported data memory.
// Latency: request sampled in IDLE -> ack 2 cycles later; one access per 3 cycles.
// Backpressure: requesters hold req and fields stable until their ack; losers simply wait.
//
// Ports: clk, reset (sync, active-high); core_* / dma_* request ports (req, we, addr, wd,
//        funct3) with ack + rd returns; dma_lock (DMA burst priority); mem_* drive the
//        memory control lines, mem_rd is the memory's read data; busy is high in ACCESS/DONE.
// Optional feature: define DMEM_ARB_RR_EN for round-robin on contested arbitrations
//        instead of fixed core priority.
module dmem_arbiter #(
    parameter int DM_ADDRESS = 9,
    parameter int DATA_W     = 32,
    parameter int MAX_BURST  = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  core_req,
    input  logic                  core_we,
    input  logic [DM_ADDRESS-1:0] core_addr,
    input  logic [DATA_W-1:0]     core_wd,
    input  logic [2:0]            core_funct3,
    input  logic                  dma_req,
    input  logic                  dma_we,
    input  logic [DM_ADDRESS-1:0] dma_addr,
    input  logic [DATA_W-1:0]     dma_wd,
    input  logic [2:0]            dma_funct3,
    input  logic                  dma_lock,
    output logic                  core_ack,
    output logic                  dma_ack,
    output logic [DATA_W-1:0]     core_rd,
    output logic [DATA_W-1:0]     dma_rd,
    output logic                  mem_read,
    output logic                  mem_write,
    output logic [DM_ADDRESS-1:0] mem_addr,
    output logic [DATA_W-1:0]     mem_wd,
    output logic [2:0]            mem_funct3,
    input  logic [DATA_W-1:0]     mem_rd,
    output logic                  busy
);

    localparam int CW = $clog2(MAX_BURST + 1);
    localparam logic [CW-1:0] MAX_CNT = CW'(MAX_BURST);

    typedef enum logic [1:0] {IDLE, ACCESS, DONE} state_t;

    state_t          state;
    logic [CW-1:0]   burst_cnt;
    logic            win_dma;     // winner of the access in flight
`ifdef DMEM_ARB_RR_EN
    logic            last_grant_dma;
`endif

    logic            any_req;
    logic            lock_win;
    logic            pick_dma;
    logic [CW-1:0]   cnt_nxt;

    // Arbitration only matters in IDLE; everything here is sampled into registers,
    // so no req reaches a mem_* output combinationally.
    always_comb begin
        any_req  = core_req || dma_req;
        lock_win = dma_lock && dma_req && (burst_cnt < MAX_CNT);
        pick_dma = 1'b0;
        cnt_nxt  = burst_cnt;

        if (lock_win) begin
            pick_dma = 1'b1;
        end else if (core_req && dma_req) begin
`ifdef DMEM_ARB_RR_EN
            pick_dma = ~last_grant_dma;
`else
            pick_dma = 1'b0;
`endif
        end else begin
            pick_dma = dma_req;
        end

        // Burst count: cleared by lock release or any core grant; only lock-won
        // DMA grants advance it. A DMA grant at MAX_CNT with the core idle leaves it saturated.
        if (!dma_lock) begin
            cnt_nxt = '0;
        end else if (any_req) begin
            if (!pick_dma)
                cnt_nxt = '0;
            else if (lock_win)
                cnt_nxt = burst_cnt + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            burst_cnt  <= '0;
            win_dma    <= 1'b0;
            mem_read   <= 1'b0;
            mem_write  <= 1'b0;
            mem_addr   <= '0;
            mem_wd     <= '0;
            mem_funct3 <= '0;
            core_ack   <= 1'b0;
            dma_ack    <= 1'b0;
            core_rd    <= '0;
            dma_rd     <= '0;
            busy       <= 1'b0;
`ifdef DMEM_ARB_RR_EN
            last_grant_dma <= 1'b1;
`endif
        end else begin
            case (state)
                IDLE: begin
                    burst_cnt <= cnt_nxt;
                    if (any_req) begin
                        win_dma    <= pick_dma;
                        mem_read   <= pick_dma ? ~dma_we : ~core_we;
                        mem_write  <= pick_dma ? dma_we : core_we;
                        mem_addr   <= pick_dma ? dma_addr : core_addr;
                        mem_wd     <= pick_dma ? dma_wd : core_wd;
                        mem_funct3 <= pick_dma ? dma_funct3 : core_funct3;
                        busy       <= 1'b1;
                        state      <= ACCESS;
`ifdef DMEM_ARB_RR_EN
                        last_grant_dma <= pick_dma;
`endif
                    end else begin
                        mem_read   <= 1'b0;
                        mem_write  <= 1'b0;
                        mem_addr   <= '0;
                        mem_wd     <= '0;
                        mem_funct3 <= '0;
                    end
                end
                ACCESS: begin
                    // Read data is captured straight into the winner's rd register;
                    // stores leave rd at zero.
                    core_rd    <= (!win_dma && mem_read) ? mem_rd : '0;
                    dma_rd     <= ( win_dma && mem_read) ? mem_rd : '0;
                    core_ack   <= ~win_dma;
                    dma_ack    <= win_dma;
                    mem_read   <= 1'b0;
                    mem_write  <= 1'b0;
                    mem_addr   <= '0;
                    mem_wd     <= '0;
                    mem_funct3 <= '0;
                    state      <= DONE;
                end
                DONE: begin
                    core_ack <= 1'b0;
                    dma_ack  <= 1'b0;
                    core_rd  <= '0;
                    dma_rd   <= '0;
                    busy     <= 1'b0;
                    state    <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req, core_we, dma_req, dma_we, dma_lock;
    logic [8:0]  core_addr, dma_addr;
    logic [31:0] core_wd, dma_wd;
    logic [2:0]  core_funct3, dma_funct3;
    logic        core_ack, dma_ack;
    logic [31:0] core_rd, dma_rd;
    logic        mem_read, mem_write, busy;
    logic [8:0]  mem_addr;
    logic [31:0] mem_wd;
    logic [2:0]  mem_funct3;
    logic [31:0] mem_rd;

    dmem_arbiter #(.DM_ADDRESS(9), .DATA_W(32), .MAX_BURST(4)) dut (
        .clk(clk), .reset(reset),
        .core_req(core_req), .core_we(core_we), .core_addr(core_addr),
        .core_wd(core_wd), .core_funct3(core_funct3),
        .dma_req(dma_req), .dma_we(dma_we), .dma_addr(dma_addr),
        .dma_wd(dma_wd), .dma_funct3(dma_funct3), .dma_lock(dma_lock),
        .core_ack(core_ack), .dma_ack(dma_ack), .core_rd(core_rd), .dma_rd(dma_rd),
        .mem_read(mem_read), .mem_write(mem_write), .mem_addr(mem_addr),
        .mem_wd(mem_wd), .mem_funct3(mem_funct3), .mem_rd(mem_rd), .busy(busy)
    );

    always #5 clk = ~clk;

    // Word-organised data memory: combinational read, write committed at the clock edge.
    logic [31:0] mem [128];
    logic        init_mem;
    always @(posedge clk) begin
        if (init_mem) begin
            for (int i = 0; i < 128; i++) mem[i] <= 32'hA000_0000 + i;
            mem[4] <= 32'hDEADBEEF;
        end else if (mem_write) begin
            mem[mem_addr[8:2]] <= mem_wd;
        end
    end
    assign mem_rd = mem[mem_addr[8:2]];

    int checks = 0;
    int errors = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Scoreboard of expected acks: who (1 = DMA) and returned data.
    typedef struct {
        logic        who;
        logic [31:0] rd;
    } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    always @(negedge clk) begin
        if (core_ack || dma_ack) begin
            chk("single_ack", {31'b0, core_ack && dma_ack}, 32'd0);
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL unexpected_ack: got core_ack=%0b dma_ack=%0b, expected none", core_ack, dma_ack);
            end else begin
                mon_e = sb.pop_front();
                chk("ack_who", {31'b0, dma_ack}, {31'b0, mon_e.who});
                chk("ack_rd", mon_e.who ? dma_rd : core_rd, mon_e.rd);
                chk("other_rd", mon_e.who ? core_rd : dma_rd, 32'd0);
            end
        end
    end

    typedef struct {
        logic        who;
        logic        we;
        logic [8:0]  addr;
        logic [31:0] wd;
        logic [2:0]  f3;
        logic [31:0] exp_rd;
    } vec_t;
    vec_t vecs[10];

    task automatic access(input vec_t v);
        int n;
        @(negedge clk);
        if (v.who) begin
            dma_req = 1'b1; dma_we = v.we; dma_addr = v.addr; dma_wd = v.wd; dma_funct3 = v.f3;
        end else begin
            core_req = 1'b1; core_we = v.we; core_addr = v.addr; core_wd = v.wd; core_funct3 = v.f3;
        end
        sb.push_back('{who: v.who, rd: v.exp_rd});
        @(posedge clk); #1;
        chk("mem_read", {31'b0, mem_read}, {31'b0, ~v.we});
        chk("mem_write", {31'b0, mem_write}, {31'b0, v.we});
        chk("mem_addr", {23'b0, mem_addr}, {23'b0, v.addr});
        chk("mem_funct3", {29'b0, mem_funct3}, {29'b0, v.f3});
        if (v.we) chk("mem_wd", mem_wd, v.wd);
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(core_ack || dma_ack) && n < 8);
        chk("ack_latency", n, 2);
        chk("strobe_len", {30'b0, mem_read, mem_write}, 32'd0);
        chk("busy_done", {31'b0, busy}, 32'd1);
        core_req = 1'b0;
        dma_req  = 1'b0;
    endtask

    initial begin
        int   n, cc, dc, tot;
        vec_t v;

        vecs[0] = '{1'b0, 1'b0, 9'h010, 32'h0,        3'b010, 32'hDEADBEEF};
        vecs[1] = '{1'b1, 1'b1, 9'h020, 32'h12345678, 3'b010, 32'h0};
        vecs[2] = '{1'b0, 1'b0, 9'h020, 32'h0,        3'b010, 32'h12345678};
        vecs[3] = '{1'b1, 1'b0, 9'h010, 32'h0,        3'b100, 32'hDEADBEEF};
        vecs[4] = '{1'b0, 1'b1, 9'h1FC, 32'hCAFEF00D, 3'b010, 32'h0};
        vecs[5] = '{1'b1, 1'b0, 9'h1FC, 32'h0,        3'b001, 32'hCAFEF00D};
        vecs[6] = '{1'b0, 1'b0, 9'h000, 32'h0,        3'b000, 32'hA0000000};
        vecs[7] = '{1'b1, 1'b1, 9'h000, 32'hFFFFFFFF, 3'b010, 32'h0};
        vecs[8] = '{1'b0, 1'b0, 9'h000, 32'h0,        3'b010, 32'hFFFFFFFF};
        vecs[9] = '{1'b1, 1'b0, 9'h040, 32'h0,        3'b101, 32'hA0000010};

        reset = 1'b1; init_mem = 1'b1;
        core_req = 0; core_we = 0; core_addr = 0; core_wd = 0; core_funct3 = 0;
        dma_req = 0; dma_we = 0; dma_addr = 0; dma_wd = 0; dma_funct3 = 0; dma_lock = 0;
        repeat (3) @(negedge clk);

        // Reset state
        chk("rst_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_addr", {23'b0, mem_addr}, 32'd0);
        chk("rst_wd", mem_wd, 32'd0);
        chk("rst_funct3", {29'b0, mem_funct3}, 32'd0);
        chk("rst_acks", {30'b0, core_ack, dma_ack}, 32'd0);
        chk("rst_rd", core_rd | dma_rd, 32'd0);
        chk("rst_busy", {31'b0, busy}, 32'd0);
        reset = 1'b0; init_mem = 1'b0;

        // Idle with no requests
        for (int i = 0; i < 10; i++) begin
            @(negedge clk);
            chk("idle", {29'b0, busy, mem_read, mem_write}, 32'd0);
        end

        // Single accesses from the table
        for (int i = 0; i < 10; i++) access(vecs[i]);

        // Contested requests, no lock
        @(negedge clk);
        core_req = 1; core_we = 0; core_addr = 9'h010; core_funct3 = 3'b010;
        dma_req = 1;  dma_we = 0;  dma_addr = 9'h040;  dma_funct3 = 3'b010;
`ifdef DMEM_ARB_RR_EN
        sb.push_back('{1'b0, 32'hDEADBEEF});
        sb.push_back('{1'b1, 32'hA0000010});
        sb.push_back('{1'b0, 32'hDEADBEEF});
`else
        sb.push_back('{1'b0, 32'hDEADBEEF});
        sb.push_back('{1'b0, 32'hDEADBEEF});
        sb.push_back('{1'b1, 32'hA0000010});
`endif
        cc = 0; dc = 0; n = 0;
        while ((core_req || dma_req) && n < 40) begin
            @(negedge clk);
            n++;
            if (core_ack) begin
                cc++;
                if (cc == 2) core_req = 0;
            end
            if (dma_ack) begin
                dc++;
                dma_req = 0;
            end
        end
        chk("contest_done", {30'b0, core_req, dma_req}, 32'd0);
        core_req = 0; dma_req = 0;

        // Burst lock: 4 DMA, 1 core, then a fresh burst of 4 DMA, then core
        @(negedge clk);
        core_req = 1; dma_req = 1; dma_lock = 1;
        for (int i = 0; i < 2; i++) begin
            repeat (4) sb.push_back('{1'b1, 32'hA0000010});
            sb.push_back('{1'b0, 32'hDEADBEEF});
        end
        tot = 0; n = 0;
        while (tot < 10 && n < 60) begin
            @(negedge clk);
            n++;
            if (core_ack || dma_ack) tot++;
            if (tot == 10) begin
                core_req = 0; dma_req = 0; dma_lock = 0;
            end
        end
        chk("burst_done", tot, 10);
        core_req = 0; dma_req = 0; dma_lock = 0;

        // Reset during ACCESS of a core store: no ack, everything cleared
        @(negedge clk);
        core_req = 1; core_we = 1; core_addr = 9'h030; core_wd = 32'h55AA55AA; core_funct3 = 3'b010;
        @(posedge clk); #1;
        chk("rst_acc_strobe", {31'b0, mem_write}, 32'd1);
        @(negedge clk);
        reset = 1; core_req = 0;
        @(negedge clk);
        chk("rst_acc_acks", {30'b0, core_ack, dma_ack}, 32'd0);
        chk("rst_acc_strobes", {30'b0, mem_read, mem_write}, 32'd0);
        chk("rst_acc_addr", {23'b0, mem_addr}, 32'd0);
        chk("rst_acc_busy", {31'b0, busy}, 32'd0);
        reset = 0;
        repeat (3) @(negedge clk);
        chk("rst_acc_no_ack", {30'b0, core_ack, dma_ack}, 32'd0);

        // The store strobe already at the memory completed; read it back
        v = '{1'b0, 1'b0, 9'h030, 32'h0, 3'b010, 32'h55AA55AA};
        access(v);
        repeat (2) @(negedge clk);

        chk("sb_empty", sb.size(), 32'd0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
